// File: rtl/fetch_pkg.sv
// Shared widths, state encoding and queue payload for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INST_WIDTH     = 32;
  localparam int unsigned ROM_DATA_WIDTH = 64;
  localparam int unsigned PC_WIDTH       = 32;
  localparam int unsigned PC_STEP        = 4;
  localparam int unsigned WAIT_WIDTH     = 3;
  localparam int unsigned QUEUE_DEPTH    = 2;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

  // Instructions are word aligned; low address bits are dropped.
  function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] addr);
    return {addr[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// ROM bus, decode handshake and redirect signals of the fetch stage.
interface instruction_fetch_if;

  logic [fetch_pkg::PC_WIDTH-1:0]       rom_address;
  logic [fetch_pkg::ROM_DATA_WIDTH-1:0] rom_data;
  logic                                 rom_chip_select;
  logic                                 rom_output_enable;
  logic [fetch_pkg::INST_WIDTH-1:0]     inst_out;
  logic [fetch_pkg::PC_WIDTH-1:0]       pc_out;
  logic                                 inst_valid;
  logic                                 inst_ready;
  logic                                 redirect;
  logic [fetch_pkg::PC_WIDTH-1:0]       redirect_pc;
  logic                                 fetch_fault;

  modport master (
    output rom_address, rom_chip_select, rom_output_enable,
    output inst_out, pc_out, inst_valid, fetch_fault,
    input  rom_data, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  rom_address, rom_chip_select, rom_output_enable,
    input  inst_out, pc_out, inst_valid, fetch_fault,
    output rom_data, inst_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry prefetch FIFO; the head is always held in its own register so
// decode sees a registered instruction/pc.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic         valid,
  output logic         full
);

  localparam int unsigned CNT_WIDTH = 2;

  fetch_entry_t         head_q, head_d;
  fetch_entry_t         tail_q, tail_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 valid_q, full_q;
  logic                 pop_ok, push_ok;

  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q != CNT_WIDTH'(QUEUE_DEPTH)) || pop_ok);

  // Shift-style update: a pop moves the tail into the head slot.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b11: begin
          if (count_q == CNT_WIDTH'(1)) begin
            head_d = push_entry;
          end else begin
            head_d = tail_q;
            tail_d = push_entry;
          end
        end
        2'b10: begin
          if (count_q == '0) head_d = push_entry;
          else               tail_d = push_entry;
          count_d = count_q + CNT_WIDTH'(1);
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - CNT_WIDTH'(1);
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= (count_d != '0);
      full_q  <= (count_d == CNT_WIDTH'(QUEUE_DEPTH));
    end
  end

  assign head  = head_q;
  assign valid = valid_q;
  assign full  = full_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the instruction ROM, waits ROM_WAIT cycles per word and
// feeds decode through a 2-entry queue. FETCH_ALIGN_CHECK_EN traps misaligned redirects.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned         ROM_WAIT = 1,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clock,
  input logic                 reset,
  instruction_fetch_if.master bus
);

  localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(ROM_WAIT);

  fetch_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [WAIT_WIDTH-1:0] wait_q, wait_d;
  logic [PC_WIDTH-1:0]   address_q, address_d;
  logic                  select_q, select_d;
  logic                  fault_q, fault_d;

  logic                  push, flush, pop, misaligned;
  logic                  q_valid, q_full;
  fetch_entry_t          q_head, q_entry;
  logic                  unused_rom_hi;

  assign unused_rom_hi = ^bus.rom_data[ROM_DATA_WIDTH-1:INST_WIDTH];

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (bus.redirect_pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign pop          = q_valid && bus.inst_ready;
  assign q_entry.pc   = fetch_pc_q;
  assign q_entry.inst = bus.rom_data[INST_WIDTH-1:0];

  fetch_queue u_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_entry (q_entry),
    .head       (q_head),
    .valid      (q_valid),
    .full       (q_full)
  );

  // select_q low in FETCH means the address has not reached the ROM yet, so
  // the wait counter only runs once the word is actually being driven.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wait_d     = wait_q;
    select_d   = select_q;
    address_d  = address_q;
    fault_d    = fault_q;
    push       = 1'b0;
    flush      = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        if (!select_q) begin
          select_d  = 1'b1;
          address_d = fetch_pc_q;
        end else if (wait_q != WAIT_LAST) begin
          wait_d = wait_q + WAIT_WIDTH'(1);
        end else if (!q_full || pop) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_WIDTH'(PC_STEP);
          wait_d     = '0;
          address_d  = fetch_pc_d;
        end else begin
          state_d  = ST_HOLD;
          select_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (pop) begin
          state_d   = ST_FETCH;
          select_d  = 1'b1;
          wait_d    = '0;
          address_d = fetch_pc_q;
        end
      end
      ST_FAULT: begin
      end
      default: state_d = ST_FETCH;
    endcase

    // A redirect discards any capture due this cycle and restarts the fetch.
    if (bus.redirect && (state_q != ST_FAULT)) begin
      push   = 1'b0;
      flush  = 1'b1;
      wait_d = '0;
      if (misaligned) begin
        state_d    = ST_FAULT;
        select_d   = 1'b0;
        fault_d    = 1'b1;
        fetch_pc_d = fetch_pc_q;
        address_d  = address_q;
      end else begin
        state_d    = ST_FETCH;
        fetch_pc_d = word_align(bus.redirect_pc);
        select_d   = 1'b1;
        address_d  = fetch_pc_d;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      wait_q     <= '0;
      address_q  <= '0;
      select_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wait_q     <= wait_d;
      address_q  <= address_d;
      select_q   <= select_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.rom_address       = address_q;
  assign bus.rom_chip_select   = select_q;
  assign bus.rom_output_enable = select_q;
  assign bus.inst_out          = q_head.inst;
  assign bus.pc_out            = q_head.pc;
  assign bus.inst_valid        = q_valid;
  assign bus.fetch_fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: two instances (ROM_WAIT 0 and 2) share stimulus,
// each checked every cycle against a queue-based model plus literal expectations.
module tb_instruction_fetch;
  import fetch_pkg::*;

  localparam int unsigned NUM_DUT = 2;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ready = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  int          tests = 0;
  int          fails = 0;

  logic [31:0] obs_addr  [NUM_DUT];
  logic [31:0] obs_pc    [NUM_DUT];
  logic [31:0] obs_inst  [NUM_DUT];
  logic        obs_cs    [NUM_DUT];
  logic        obs_oe    [NUM_DUT];
  logic        obs_valid [NUM_DUT];
  logic        obs_fault [NUM_DUT];

  always #5 clock = ~clock;

  // Mapped ROM: low 128 bytes and the top 256 bytes; instruction = ~address.
  function automatic logic [63:0] rom_word(input logic [31:0] a);
    if (a < 32'h80 || a >= 32'hFFFF_FF00) return {32'hCAFE_F00D, ~a};
    return 64'h0;
  endfunction

  function automatic void check(input string name, input int dut,
                                input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, dut, got, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < NUM_DUT; g++) begin : g_dut
    localparam int unsigned W = 2 * g;

    instruction_fetch_if bus ();
    assign bus.rom_data    = rom_word(bus.rom_address);
    assign bus.inst_ready  = ready;
    assign bus.redirect    = redirect;
    assign bus.redirect_pc = redirect_pc;

    instruction_fetch #(.ROM_WAIT(W), .RESET_PC(32'h0)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
    );

    assign obs_addr[g]  = bus.rom_address;
    assign obs_pc[g]    = bus.pc_out;
    assign obs_inst[g]  = bus.inst_out;
    assign obs_cs[g]    = bus.rom_chip_select;
    assign obs_oe[g]    = bus.rom_output_enable;
    assign obs_valid[g] = bus.inst_valid;
    assign obs_fault[g] = bus.fetch_fault;

    fetch_entry_t mq [$];
    logic [31:0]  m_pc = 32'h0;
    logic [31:0]  m_addr = 32'h0;
    int unsigned  m_wait = 0;
    bit           m_present = 1'b0;
    bit           m_stalled = 1'b0;
    bit           m_dead = 1'b0;
    bit           m_fault = 1'b0;
    bit           m_live = 1'b0;

    // Behavioural model of one clock edge.
    always @(posedge clock) begin : model_step
      int           n;
      bit           popped;
      logic [63:0]  word;
      fetch_entry_t e;
      if (reset) begin
        mq.delete();
        m_pc = 32'h0; m_addr = 32'h0; m_wait = 0;
        m_present = 1'b0; m_stalled = 1'b0; m_dead = 1'b0; m_fault = 1'b0;
        m_live = 1'b1;
      end else begin
        n = mq.size();
        popped = (n > 0) && ready;
        if (popped) void'(mq.pop_front());
        if (redirect && !m_dead) begin
          mq.delete();
          if (ALIGN_CHECK && redirect_pc[1:0] != 2'b00) begin
            m_dead = 1'b1; m_fault = 1'b1; m_present = 1'b0; m_stalled = 1'b0;
          end else begin
            m_pc = {redirect_pc[31:2], 2'b00};
            m_addr = m_pc; m_present = 1'b1; m_wait = 0; m_stalled = 1'b0;
          end
        end else if (m_dead) begin
        end else if (m_stalled) begin
          if (popped) begin
            m_stalled = 1'b0; m_present = 1'b1; m_addr = m_pc; m_wait = 0;
          end
        end else if (!m_present) begin
          m_present = 1'b1; m_addr = m_pc;
        end else if (m_wait < W) begin
          m_wait++;
        end else if (n < 2 || popped) begin
          word = rom_word(m_pc);
          e.pc = m_pc;
          e.inst = word[31:0];
          mq.push_back(e);
          m_pc = m_pc + 32'd4;
          m_addr = m_pc; m_wait = 0;
        end else begin
          m_stalled = 1'b1; m_present = 1'b0;
        end
      end
    end

    always @(negedge clock) begin
      if (m_live) begin
        check("rom_address", g, bus.rom_address, m_addr);
        check("rom_chip_select", g, 32'(bus.rom_chip_select), 32'(m_present));
        check("rom_output_enable", g, 32'(bus.rom_output_enable), 32'(m_present));
        check("inst_valid", g, 32'(bus.inst_valid), 32'(mq.size() != 0));
        check("fetch_fault", g, 32'(bus.fetch_fault), 32'(m_fault));
        if (mq.size() != 0) begin
          check("pc_out", g, bus.pc_out, mq[0].pc);
          check("inst_out", g, bus.inst_out, mq[0].inst);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic skip(input int n);
    repeat (n) next_cycle();
  endtask

  // Leaves the bench at the start of cycle 0 (first cycle with reset low).
  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    redirect = 1'b0;
    ready = rdy;
    skip(2);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] pat;
    pat = 32'hB271_CA69;
    next_cycle();

    // Reset values, then ROM_WAIT 0/2 streaming with ready high.
    do_reset(1'b1);
    @(negedge clock);
    check("reset rom_address", 0, obs_addr[0], 32'h0);
    check("reset chip_select", 0, 32'(obs_cs[0]), 32'h0);
    check("reset output_enable", 0, 32'(obs_oe[0]), 32'h0);
    check("reset inst_valid", 0, 32'(obs_valid[0]), 32'h0);
    check("reset inst_out", 0, obs_inst[0], 32'h0);
    check("reset pc_out", 0, obs_pc[0], 32'h0);
    check("reset fetch_fault", 0, 32'(obs_fault[0]), 32'h0);
    next_cycle(); @(negedge clock);                       // cycle 1
    check("first address cs", 0, 32'(obs_cs[0]), 32'h1);
    check("first address", 0, obs_addr[0], 32'h0);
    check("no valid yet", 0, 32'(obs_valid[0]), 32'h0);
    next_cycle(); @(negedge clock);                       // cycle 2
    check("w0 first valid", 0, 32'(obs_valid[0]), 32'h1);
    check("w0 pc 0", 0, obs_pc[0], 32'h0);
    check("w0 inst 0", 0, obs_inst[0], 32'hFFFF_FFFF);
    check("w2 address held", 1, obs_addr[1], 32'h0);
    next_cycle(); @(negedge clock);                       // cycle 3
    check("w0 pc 4", 0, obs_pc[0], 32'h4);
    check("w0 inst 4", 0, obs_inst[0], 32'hFFFF_FFFB);
    check("w2 address held", 1, obs_addr[1], 32'h0);
    next_cycle(); @(negedge clock);                       // cycle 4
    check("w0 pc 8", 0, obs_pc[0], 32'h8);
    check("w2 first valid pc", 1, obs_pc[1], 32'h0);
    check("w2 next address", 1, obs_addr[1], 32'h4);
    next_cycle(); @(negedge clock);                       // cycle 5
    check("w2 popped", 1, 32'(obs_valid[1]), 32'h0);
    skip(2); @(negedge clock);                            // cycle 7
    check("w2 second valid pc", 1, obs_pc[1], 32'h4);
    check("w2 third address", 1, obs_addr[1], 32'h8);

    // Back-pressure: queue fills, CS/OE drop, then drains and refetches 8.
    do_reset(1'b0);
    skip(5); @(negedge clock);                            // cycle 5
    check("hold cs", 0, 32'(obs_cs[0]), 32'h0);
    check("hold oe", 0, 32'(obs_oe[0]), 32'h0);
    check("hold address", 0, obs_addr[0], 32'h8);
    check("hold head pc", 0, obs_pc[0], 32'h0);
    next_cycle(); ready = 1'b1; @(negedge clock);         // cycle 6
    check("drain pc 0", 0, obs_pc[0], 32'h0);
    next_cycle(); @(negedge clock);                       // cycle 7
    check("drain pc 4", 0, obs_pc[0], 32'h4);
    check("refetch cs", 0, 32'(obs_cs[0]), 32'h1);
    next_cycle(); @(negedge clock);                       // cycle 8
    check("refetch pc 8", 0, obs_pc[0], 32'h8);
    check("refetch inst 8", 0, obs_inst[0], 32'hFFFF_FFF7);

    // Redirect to 0x40 while the queue is full.
    do_reset(1'b0);
    skip(5);                                              // cycle 5
    redirect = 1'b1; redirect_pc = 32'h40;
    next_cycle(); redirect = 1'b0; @(negedge clock);      // cycle 6
    check("redirect flush w0", 0, 32'(obs_valid[0]), 32'h0);
    check("redirect flush w2", 1, 32'(obs_valid[1]), 32'h0);
    check("redirect address", 0, obs_addr[0], 32'h40);
    next_cycle(); @(negedge clock);                       // cycle 7
    check("redirect pc w0", 0, obs_pc[0], 32'h40);
    check("redirect inst w0", 0, obs_inst[0], 32'hFFFF_FFBF);
    skip(2); @(negedge clock);                            // cycle 9
    check("redirect pc w2", 1, obs_pc[1], 32'h40);

    // Misaligned redirect.
    next_cycle();                                         // cycle 10
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h42;
    next_cycle(); redirect = 1'b0; @(negedge clock);      // cycle 11
`ifdef FETCH_ALIGN_CHECK_EN
    check("fault set", 0, 32'(obs_fault[0]), 32'h1);
    check("fault cs", 0, 32'(obs_cs[0]), 32'h0);
    skip(3); @(negedge clock);                            // cycle 14
    check("fault sticky", 0, 32'(obs_fault[0]), 32'h1);
    check("fault no valid", 0, 32'(obs_valid[0]), 32'h0);
    check("fault no fetch w2", 1, 32'(obs_cs[1]), 32'h0);
`else
    check("aligned address", 0, obs_addr[0], 32'h40);
    next_cycle(); @(negedge clock);                       // cycle 12
    check("aligned pc", 0, obs_pc[0], 32'h40);
    skip(2); @(negedge clock);                            // cycle 14
    check("fault tied low", 0, 32'(obs_fault[0]), 32'h0);
`endif

    // Wrap from 0xFFFFFFFC to 0.
    do_reset(1'b1);
    skip(2);                                              // cycle 2
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    next_cycle(); redirect = 1'b0;                        // cycle 3
    next_cycle(); @(negedge clock);                       // cycle 4
    check("wrap pc top", 0, obs_pc[0], 32'hFFFF_FFFC);
    check("wrap inst top", 0, obs_inst[0], 32'h0000_0003);
    next_cycle(); @(negedge clock);                       // cycle 5
    check("wrap pc zero", 0, obs_pc[0], 32'h0);
    next_cycle(); @(negedge clock);                       // cycle 6
    check("wrap pc top w2", 1, obs_pc[1], 32'hFFFF_FFFC);
    skip(3); @(negedge clock);                            // cycle 9
    check("wrap pc zero w2", 1, obs_pc[1], 32'h0);

    // Unmapped words pass through as zero instructions.
    next_cycle();                                         // cycle 10
    redirect = 1'b1; redirect_pc = 32'h100;
    next_cycle(); redirect = 1'b0;                        // cycle 11
    next_cycle(); @(negedge clock);                       // cycle 12
    check("unmapped pc", 0, obs_pc[0], 32'h100);
    check("unmapped inst", 0, obs_inst[0], 32'h0);

    // Irregular ready pattern with a mid-stream redirect; model checks each cycle.
    next_cycle();
    redirect = 1'b1; redirect_pc = 32'h10;
    next_cycle(); redirect = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ready = pat[i % 32];
      redirect = (i == 23) || (i == 47);
      redirect_pc = (i == 23) ? 32'h20 : 32'hFFFF_FFF4;
      next_cycle();
    end
    redirect = 1'b0;
    skip(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
